// File: rtl/lv1b_pkg.sv
// Shared types and constants for the lv1b trigger controller.
// TAG_TRAILER_EN (optional) adds an XOR trailer word to each tag frame.
package lv1b_pkg;

  localparam logic [15:0] TAG_HEADER = 16'hEEEE;

  localparam logic [3:0] W_HDR        = 4'd0;
  localparam logic [3:0] W_ID         = 4'd1;
  localparam logic [3:0] W_VETO_LO    = 4'd2;
  localparam logic [3:0] W_VETO_HI    = 4'd3;
  localparam logic [3:0] W_TS_LO      = 4'd4;
  localparam logic [3:0] W_TS_HI      = 4'd5;
  localparam logic [3:0] W_INT_SCALED = 4'd6;
  localparam logic [3:0] W_MISC       = 4'd7;
  localparam logic [3:0] W_ET         = 4'd8;
  localparam logic [3:0] W_INT_RAW    = 4'd9;
  localparam logic [3:0] W_TRAILER    = 4'd10;

  typedef struct packed {
    logic [9:0]  event_id;
    logic [31:0] veto;
    logic [31:0] ts;
    logic [15:0] int_scaled;
    logic [15:0] int_raw;
    logic [3:0]  nclus;
    logic [3:0]  ext;
    logic        delta;
    logic [15:0] et;
  } tag_snap_t;

  typedef enum logic [1:0] {SER_IDLE, SER_SEND, SER_GAP} ser_state_t;

  function automatic logic [15:0] tag_base_word(input tag_snap_t s, input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      W_HDR:        w = TAG_HEADER;
      W_ID:         w = {6'b0, s.event_id};
      W_VETO_LO:    w = s.veto[15:0];
      W_VETO_HI:    w = s.veto[31:16];
      W_TS_LO:      w = s.ts[15:0];
      W_TS_HI:      w = s.ts[31:16];
      W_INT_SCALED: w = s.int_scaled;
      W_MISC:       w = {7'b0, s.delta, s.ext, s.nclus};
      W_ET:         w = s.et;
      W_INT_RAW:    w = s.int_raw;
      default:      w = 16'h0000;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] tag_trailer(input tag_snap_t s);
    logic [15:0] x;
    x = 16'h0000;
    for (int i = 0; i <= int'(W_INT_RAW); i++) x = x ^ tag_base_word(s, 4'(i));
    return x;
  endfunction

endpackage

// File: rtl/lv1b_tag_fifo.sv
// Snapshot queue for accepted events; push is legal on full when a pop
// happens on the same edge.
module lv1b_tag_fifo import lv1b_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  tag_snap_t din,
  output tag_snap_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  tag_snap_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/lv1b_trig_ctrl.sv
// lv1b trigger controller: lv1 delay pipeline, inhibit window and tag-frame serializer.
// TAG_TRAILER_EN appends an XOR trailer word to each frame.
module lv1b_trig_ctrl import lv1b_pkg::*; #(
  parameter int PIPE      = 256,
  parameter int N_INT     = 16,
  parameter int N_EXT     = 4,
  parameter int INH_PRE   = 4,
  parameter int INH_LEN   = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_live,
  input  logic                    in_lv1b_req,
  input  logic [N_INT-1:0]        in_int_raw,
  input  logic [N_INT-1:0]        in_int_scaled,
  input  logic [N_EXT-1:0]        in_ext,
  input  logic                    in_delta,
  input  logic [15:0]             in_et_raw,
  input  logic [31:0]             in_veto_raw,
  input  logic [3:0]              in_nclus,
  input  logic [31:0]             in_timestamp,
  input  logic [$clog2(PIPE)-1:0] delay_lv1,
  input  logic                    lv2_full,
  output logic                    out_lv1,
  output logic                    out_early_lv1,
  output logic                    out_lv1_inhibit,
  output logic [15:0]             out_trig_tag,
  output logic                    out_tag_valid,
  output logic [19:0]             lv1_cnt,
  output logic [31:0]             lv2_rej_cnt,
  output logic [15:0]             tag_ovf_cnt
);

  localparam int DW = $clog2(PIPE);
`ifdef TAG_TRAILER_EN
  localparam logic [3:0] LAST_W = W_TRAILER;
`else
  localparam logic [3:0] LAST_W = W_INT_RAW;
`endif

  // state    | meaning
  // SER_IDLE | no frame; load from queue, or straight from inputs when queue empty
  // SER_SEND | presenting word idx_q of cur_q
  // SER_GAP  | one idle word between frames; may load the next frame
  ser_state_t  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  tag_snap_t   cur_q, cur_d;

  logic [PIPE-1:0] pipe_q;
  logic [9:0]      event_id_q;
  logic            live_q;
  tag_snap_t       snap, q_dout;
  logic            q_full, q_empty;
  logic            cand, load_ok, pop, q_blocked, accept, bypass, push;
  logic            rej_lv2, rej_ovf, lv1_next, lv1_fire, live_rise;
  int              inh_lo, inh_hi;

  assign cand      = in_live & in_lv1b_req & (|in_int_scaled | |in_ext | in_delta);
  assign load_ok   = (state_q == SER_IDLE) || (state_q == SER_GAP);
  assign pop       = in_live & load_ok & ~q_empty;
  assign q_blocked = q_full & ~pop;
  assign rej_lv2   = cand & lv2_full;
  assign rej_ovf   = cand & ~lv2_full & q_blocked;
  assign accept    = cand & ~lv2_full & ~q_blocked;
  // An idle serializer with nothing queued starts the header on the next clock
  assign bypass    = accept & load_ok & q_empty;
  assign push      = accept & ~bypass;
  assign live_rise = in_live & ~live_q;

  // pipe_q[i] is visible i+1 clocks after acceptance, so tap one position early
  assign lv1_next  = (delay_lv1 == '0) ? accept : pipe_q[delay_lv1 - DW'(1)];
  assign lv1_fire  = in_live & lv1_next;

  always_comb begin
    snap            = '0;
    snap.event_id   = event_id_q;
    snap.veto       = in_veto_raw;
    snap.ts         = in_timestamp;
    snap.int_scaled = 16'(in_int_scaled);
    snap.int_raw    = 16'(in_int_raw);
    snap.nclus      = in_nclus;
    snap.ext        = 4'(in_ext);
    snap.delta      = in_delta;
    snap.et         = in_et_raw;
  end

  always_comb begin
    inh_lo = int'(delay_lv1) - INH_PRE;
    if (inh_lo < 0) inh_lo = 0;
    inh_hi = int'(delay_lv1) - INH_PRE + INH_LEN - 1;
    if (inh_hi > PIPE-1) inh_hi = PIPE-1;
    out_lv1_inhibit = 1'b0;
    for (int i = 0; i < PIPE; i++)
      if (pipe_q[i] && i >= inh_lo && i <= inh_hi) out_lv1_inhibit = 1'b1;
  end

  lv1b_tag_fifo #(.DEPTH(TAG_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (~in_live),
    .push  (push),
    .pop   (pop),
    .din   (snap),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q        <= '0;
      out_lv1       <= 1'b0;
      out_early_lv1 <= 1'b0;
      event_id_q    <= '0;
      live_q        <= 1'b0;
      lv1_cnt       <= '0;
      lv2_rej_cnt   <= '0;
      tag_ovf_cnt   <= '0;
    end else begin
      live_q      <= in_live;
      lv1_cnt     <= (live_rise ? 20'd0 : lv1_cnt) + 20'(lv1_fire);
      lv2_rej_cnt <= (live_rise ? 32'd0 : lv2_rej_cnt) + 32'(rej_lv2);
      tag_ovf_cnt <= (live_rise ? 16'd0 : tag_ovf_cnt) + 16'(rej_ovf);
      if (!in_live) begin
        pipe_q        <= '0;
        out_lv1       <= 1'b0;
        out_early_lv1 <= 1'b0;
        event_id_q    <= '0;
      end else begin
        pipe_q        <= {pipe_q[PIPE-2:0], accept};
        out_lv1       <= lv1_next;
        out_early_lv1 <= accept;
        if (accept) event_id_q <= event_id_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      idx_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    if (!in_live) begin
      state_d = SER_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        SER_IDLE, SER_GAP: begin
          state_d = SER_IDLE;
          if (!q_empty) begin
            state_d = SER_SEND;
            idx_d   = W_HDR;
            cur_d   = q_dout;
          end else if (accept) begin
            state_d = SER_SEND;
            idx_d   = W_HDR;
            cur_d   = snap;
          end
        end
        SER_SEND: begin
          if (idx_q == LAST_W) state_d = SER_GAP;
          else idx_d = idx_q + 4'd1;
        end
        default: state_d = SER_IDLE;
      endcase
    end
  end

  always_comb begin
    out_trig_tag  = 16'h0000;
    out_tag_valid = 1'b0;
    if (state_q == SER_SEND) begin
      out_tag_valid = 1'b1;
`ifdef TAG_TRAILER_EN
      out_trig_tag = (idx_q == W_TRAILER) ? tag_trailer(cur_q) : tag_base_word(cur_q, idx_q);
`else
      out_trig_tag = tag_base_word(cur_q, idx_q);
`endif
    end
  end

endmodule
